// File: rtl/cnn_pkg.sv
// Shared CNN accelerator definitions: weight stream geometry, the weight-receiver
// state encoding and a beat-to-channel slicing helper.
package cnn_pkg;

  localparam int unsigned CH_NUM          = 8;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned BEAT_W          = CH_NUM * DATA_W;
  localparam int unsigned L2_WEIGHT_DEPTH = 576;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } rx_state_e;

  // Channel k of a packed beat occupies bits [DATA_W*k +: DATA_W].
  function automatic logic [DATA_W-1:0] beat_ch(input logic [BEAT_W-1:0] beat,
                                                input int unsigned       k);
    return beat[k*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/weight_buf_ram.sv
// Simple dual-port weight buffer: one write port, one registered read-first read port.
module weight_buf_ram #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 576,
  parameter int unsigned AW    = 10
) (
  input  logic          sclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Both ports in one block so a same-address read sees the pre-write contents.
  always_ff @(posedge sclk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/layer_weight_rx.sv
// Layer weight stream receiver: loads one layer of beats into the weight buffer,
// checks the frame length, and serves 1-cycle-latency reads to the conv engine.
module layer_weight_rx #(
  parameter int unsigned CH_NUM = cnn_pkg::CH_NUM,
  parameter int unsigned DATA_W = cnn_pkg::DATA_W,
  parameter int unsigned DEPTH  = cnn_pkg::L2_WEIGHT_DEPTH,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                     sclk,
  input  logic                     s_rst,
  input  logic                     load_start,
  input  logic [CH_NUM*DATA_W-1:0] weight_data,
  input  logic                     weight_valid,
  input  logic                     weight_last,
  output logic                     ready,
  output logic                     weight_loaded,
  output logic                     len_err,
  output logic [AW-1:0]            wr_cnt,
  input  logic                     rd_en,
  input  logic [AW-1:0]            rd_addr,
  output logic [CH_NUM*DATA_W-1:0] rd_data,
  output logic                     rd_valid
);
  import cnn_pkg::*;

  localparam int unsigned   BW       = CH_NUM * DATA_W;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);

  rx_state_e      state;
  logic           beat_acc;
  logic           rd_in_range;
  logic           rd_zero;
  logic [BW-1:0]  ram_rdata;

  assign beat_acc    = weight_valid && ready;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

  // Load FSM; ready mirrors the LOAD state as its own flop.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state         <= ST_IDLE;
      ready         <= 1'b0;
      weight_loaded <= 1'b0;
      len_err       <= 1'b0;
      wr_cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (load_start) begin
            state         <= ST_LOAD;
            ready         <= 1'b1;
            weight_loaded <= 1'b0;
            len_err       <= 1'b0;
            wr_cnt        <= '0;
          end
        end
        ST_LOAD: begin
          if (beat_acc) begin
            wr_cnt <= wr_cnt + AW'(1);
            if (wr_cnt == LAST_IDX) begin
              ready <= 1'b0;
              if (weight_last) begin
                state         <= ST_DONE;
                weight_loaded <= 1'b1;
              end else begin
                state   <= ST_IDLE;
                len_err <= 1'b1;
              end
            end else if (weight_last) begin
              state   <= ST_IDLE;
              ready   <= 1'b0;
              len_err <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Out-of-range reads return zero; rd_zero also masks the unreset RAM output.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      rd_valid <= 1'b0;
      rd_zero  <= 1'b1;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_zero <= !rd_in_range;
    end
  end

  assign rd_data = rd_zero ? '0 : ram_rdata;

  weight_buf_ram #(
    .DW    (BW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .sclk  (sclk),
    .we    (beat_acc),
    .waddr (wr_cnt),
    .wdata (weight_data),
    .re    (rd_en && rd_in_range),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_layer_weight_rx.sv
// Directed bench for layer_weight_rx: full/gapped loads, length errors, reset, reads.
module tb_layer_weight_rx;

  logic        sclk = 1'b0;
  logic        s_rst = 1'b1;
  logic        load_start = 1'b0;
  logic [63:0] weight_data = '0;
  logic        weight_valid = 1'b0;
  logic        weight_last = 1'b0;
  logic        ready;
  logic        weight_loaded;
  logic        len_err;
  logic [9:0]  wr_cnt;
  logic        rd_en = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic        rd_valid;

  int n_vec  = 0;
  int n_miss = 0;

  layer_weight_rx dut (
    .sclk          (sclk),
    .s_rst         (s_rst),
    .load_start    (load_start),
    .weight_data   (weight_data),
    .weight_valid  (weight_valid),
    .weight_last   (weight_last),
    .ready         (ready),
    .weight_loaded (weight_loaded),
    .len_err       (len_err),
    .wr_cnt        (wr_cnt),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid)
  );

  always #5 sclk = ~sclk;

  // Beat i, channel k carries (i+k) & 0xFF.
  function automatic logic [63:0] ramp(input int i);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = 8'((i + k) & 255);
    return v;
  endfunction

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  task automatic pulse_start;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic do_read(input int addr);
    rd_en   = 1'b1;
    rd_addr = 10'(addr);
    tick();
    rd_en   = 1'b0;
  endtask

  // Source model: sends beats [first, first+count), honouring ready, with random idle cycles.
  task automatic send_beats(input int first, input int count, input int last_idx,
                            input int gap_pct, input logic [63:0] mask, output int cycles);
    int  i      = first;
    int  budget = count * 4 + 100;
    logic acc;
    cycles = 0;
    while (i < first + count && budget > 0) begin
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        weight_valid = 1'b0;
        weight_last  = 1'b0;
      end else begin
        weight_valid = 1'b1;
        weight_data  = ramp(i) ^ mask;
        weight_last  = (i == last_idx);
      end
      acc = weight_valid && ready;
      tick();
      cycles++;
      budget--;
      if (acc) i++;
    end
    weight_valid = 1'b0;
    weight_last  = 1'b0;
    if (i != first + count) begin
      n_miss++;
      $display("FAIL send_timeout: sent %0d beats want %0d", i - first, count);
    end
    n_vec++;
  endtask

  task automatic test_reset;
    s_rst = 1'b1;
    tick(); tick();
    if (ready !== 1'b0) begin n_miss++; $display("FAIL rst_ready: got %b want 0", ready); end n_vec++;
    if (weight_loaded !== 1'b0) begin n_miss++; $display("FAIL rst_loaded: got %b want 0", weight_loaded); end n_vec++;
    if (len_err !== 1'b0) begin n_miss++; $display("FAIL rst_len_err: got %b want 0", len_err); end n_vec++;
    if (wr_cnt !== 10'd0) begin n_miss++; $display("FAIL rst_wr_cnt: got %0d want 0", wr_cnt); end n_vec++;
    if (rd_valid !== 1'b0) begin n_miss++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end n_vec++;
    if (rd_data !== 64'h0) begin n_miss++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end n_vec++;
    s_rst = 1'b0;
    tick();
    if (ready !== 1'b0) begin n_miss++; $display("FAIL idle_ready: got %b want 0", ready); end n_vec++;
  endtask

  task automatic test_full_load;
    int cyc;
    pulse_start();
    if (ready !== 1'b1) begin n_miss++; $display("FAIL full_ready: got %b want 1", ready); end n_vec++;
    send_beats(0, 576, 575, 0, 64'h0, cyc);
    if (cyc !== 576) begin n_miss++; $display("FAIL full_cycles: got %0d want 576", cyc); end n_vec++;
    if (weight_loaded !== 1'b1) begin n_miss++; $display("FAIL full_loaded: got %b want 1", weight_loaded); end n_vec++;
    if (len_err !== 1'b0) begin n_miss++; $display("FAIL full_len_err: got %b want 0", len_err); end n_vec++;
    if (ready !== 1'b0) begin n_miss++; $display("FAIL full_ready_drop: got %b want 0", ready); end n_vec++;
    if (wr_cnt !== 10'd576) begin n_miss++; $display("FAIL full_wr_cnt: got %0d want 576", wr_cnt); end n_vec++;
    do_read(0);
    if (rd_data !== 64'h0706050403020100) begin n_miss++; $display("FAIL full_rd0: got %h want 0706050403020100", rd_data); end n_vec++;
    if (rd_valid !== 1'b1) begin n_miss++; $display("FAIL full_rd_valid: got %b want 1", rd_valid); end n_vec++;
    do_read(300);
    if (rd_data !== 64'h333231302F2E2D2C) begin n_miss++; $display("FAIL full_rd300: got %h want 333231302f2e2d2c", rd_data); end n_vec++;
    do_read(575);
    if (rd_data !== 64'h464544434241403F) begin n_miss++; $display("FAIL full_rd575: got %h want 464544434241403f", rd_data); end n_vec++;
    tick();
    if (rd_valid !== 1'b0) begin n_miss++; $display("FAIL rd_idle_valid: got %b want 0", rd_valid); end n_vec++;
    if (rd_data !== 64'h464544434241403F) begin n_miss++; $display("FAIL rd_hold: got %h want 464544434241403f", rd_data); end n_vec++;
  endtask

  task automatic test_gap_load;
    int cyc;
    pulse_start();
    if (weight_loaded !== 1'b0) begin n_miss++; $display("FAIL gap_loaded_clr: got %b want 0", weight_loaded); end n_vec++;
    send_beats(0, 576, 575, 30, 64'h0, cyc);
    if (cyc <= 576) begin n_miss++; $display("FAIL gap_cycles: got %0d want >576", cyc); end n_vec++;
    if (wr_cnt !== 10'd576) begin n_miss++; $display("FAIL gap_wr_cnt: got %0d want 576", wr_cnt); end n_vec++;
    if (weight_loaded !== 1'b1) begin n_miss++; $display("FAIL gap_loaded: got %b want 1", weight_loaded); end n_vec++;
    for (int a = 0; a < 576; a++) begin
      do_read(a);
      if (rd_data !== ramp(a)) begin n_miss++; $display("FAIL gap_rd[%0d]: got %h want %h", a, rd_data, ramp(a)); end n_vec++;
    end
  endtask

  task automatic test_early_last;
    int cyc;
    pulse_start();
    send_beats(0, 101, 100, 0, 64'h0, cyc);
    if (ready !== 1'b0) begin n_miss++; $display("FAIL early_ready: got %b want 0", ready); end n_vec++;
    if (len_err !== 1'b1) begin n_miss++; $display("FAIL early_len_err: got %b want 1", len_err); end n_vec++;
    if (weight_loaded !== 1'b0) begin n_miss++; $display("FAIL early_loaded: got %b want 0", weight_loaded); end n_vec++;
    if (wr_cnt !== 10'd101) begin n_miss++; $display("FAIL early_wr_cnt: got %0d want 101", wr_cnt); end n_vec++;
    pulse_start();
    if (len_err !== 1'b0) begin n_miss++; $display("FAIL early_clr_err: got %b want 0", len_err); end n_vec++;
    if (ready !== 1'b1) begin n_miss++; $display("FAIL early_rearm: got %b want 1", ready); end n_vec++;
    if (wr_cnt !== 10'd0) begin n_miss++; $display("FAIL early_clr_cnt: got %0d want 0", wr_cnt); end n_vec++;
  endtask

  task automatic test_ignore_start;
    int cyc;
    send_beats(0, 10, -1, 0, 64'h0, cyc);
    if (wr_cnt !== 10'd10) begin n_miss++; $display("FAIL ign_wr_cnt0: got %0d want 10", wr_cnt); end n_vec++;
    weight_valid = 1'b1;
    weight_data  = ramp(10);
    load_start   = 1'b1;
    tick();
    load_start   = 1'b0;
    weight_valid = 1'b0;
    if (wr_cnt !== 10'd11) begin n_miss++; $display("FAIL ign_wr_cnt: got %0d want 11", wr_cnt); end n_vec++;
    if (ready !== 1'b1) begin n_miss++; $display("FAIL ign_ready: got %b want 1", ready); end n_vec++;
  endtask

  task automatic test_missing_last;
    int cyc;
    send_beats(11, 565, -1, 0, 64'h0, cyc);
    if (len_err !== 1'b1) begin n_miss++; $display("FAIL miss_len_err: got %b want 1", len_err); end n_vec++;
    if (weight_loaded !== 1'b0) begin n_miss++; $display("FAIL miss_loaded: got %b want 0", weight_loaded); end n_vec++;
    if (wr_cnt !== 10'd576) begin n_miss++; $display("FAIL miss_wr_cnt: got %0d want 576", wr_cnt); end n_vec++;
    weight_valid = 1'b1;
    weight_data  = ramp(576);
    for (int c = 0; c < 3; c++) begin
      if (ready !== 1'b0) begin n_miss++; $display("FAIL miss_stall_ready[%0d]: got %b want 0", c, ready); end n_vec++;
      tick();
      if (wr_cnt !== 10'd576) begin n_miss++; $display("FAIL miss_stall_cnt[%0d]: got %0d want 576", c, wr_cnt); end n_vec++;
    end
    weight_valid = 1'b0;
  endtask

  task automatic test_reset_mid_load;
    int cyc;
    pulse_start();
    send_beats(0, 300, -1, 0, '1, cyc);
    weight_valid = 1'b1;
    weight_data  = ~ramp(300);
    rd_en        = 1'b1;
    rd_addr      = 10'd0;
    s_rst        = 1'b1;
    tick();
    s_rst        = 1'b0;
    weight_valid = 1'b0;
    rd_en        = 1'b0;
    if (ready !== 1'b0) begin n_miss++; $display("FAIL mrst_ready: got %b want 0", ready); end n_vec++;
    if (wr_cnt !== 10'd0) begin n_miss++; $display("FAIL mrst_wr_cnt: got %0d want 0", wr_cnt); end n_vec++;
    if (len_err !== 1'b0) begin n_miss++; $display("FAIL mrst_len_err: got %b want 0", len_err); end n_vec++;
    if (weight_loaded !== 1'b0) begin n_miss++; $display("FAIL mrst_loaded: got %b want 0", weight_loaded); end n_vec++;
    if (rd_valid !== 1'b0) begin n_miss++; $display("FAIL mrst_rd_valid: got %b want 0", rd_valid); end n_vec++;
    if (rd_data !== 64'h0) begin n_miss++; $display("FAIL mrst_rd_data: got %h want 0", rd_data); end n_vec++;
    pulse_start();
    send_beats(0, 576, 575, 0, '1, cyc);
    if (weight_loaded !== 1'b1) begin n_miss++; $display("FAIL mrst_reload: got %b want 1", weight_loaded); end n_vec++;
    if (len_err !== 1'b0) begin n_miss++; $display("FAIL mrst_reload_err: got %b want 0", len_err); end n_vec++;
    do_read(0);
    if (rd_data !== 64'hF8F9FAFBFCFDFEFF) begin n_miss++; $display("FAIL mrst_rd0: got %h want f8f9fafbfcfdfeff", rd_data); end n_vec++;
    do_read(300);
    if (rd_data !== 64'hCCCDCECFD0D1D2D3) begin n_miss++; $display("FAIL mrst_rd300: got %h want cccdcecfd0d1d2d3", rd_data); end n_vec++;
    do_read(575);
    if (rd_data !== 64'hB9BABBBCBDBEBFC0) begin n_miss++; $display("FAIL mrst_rd575: got %h want b9babbbcbdbebfc0", rd_data); end n_vec++;
  endtask

  task automatic test_read_first;
    int cyc;
    pulse_start();
    send_beats(0, 5, -1, 0, 64'h0, cyc);
    weight_valid = 1'b1;
    weight_data  = ramp(5);
    rd_en        = 1'b1;
    rd_addr      = 10'd5;
    tick();
    weight_valid = 1'b0;
    rd_en        = 1'b0;
    if (rd_data !== 64'hF3F4F5F6F7F8F9FA) begin n_miss++; $display("FAIL rf_old: got %h want f3f4f5f6f7f8f9fa", rd_data); end n_vec++;
    if (wr_cnt !== 10'd6) begin n_miss++; $display("FAIL rf_wr_cnt: got %0d want 6", wr_cnt); end n_vec++;
    do_read(5);
    if (rd_data !== 64'h0C0B0A0908070605) begin n_miss++; $display("FAIL rf_new: got %h want 0c0b0a0908070605", rd_data); end n_vec++;
    do_read(600);
    if (rd_data !== 64'h0) begin n_miss++; $display("FAIL oor_data: got %h want 0", rd_data); end n_vec++;
    if (rd_valid !== 1'b1) begin n_miss++; $display("FAIL oor_valid: got %b want 1", rd_valid); end n_vec++;
    tick();
    if (rd_data !== 64'h0) begin n_miss++; $display("FAIL oor_hold: got %h want 0", rd_data); end n_vec++;
    if (rd_valid !== 1'b0) begin n_miss++; $display("FAIL oor_idle_valid: got %b want 0", rd_valid); end n_vec++;
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_gap_load();
    test_early_last();
    test_ignore_start();
    test_missing_last();
    test_reset_mid_load();
    test_read_first();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
